axi_stream_fifo: RTL and testbench
==================================

AXI_STREAM_FIFO -- requirements
Module: axi_stream_fifo

Interface
- REQ-001 SHALL have parameter N, default 4: lanes per beat.
- REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per lane.
- REQ-003 SHALL have parameter DEPTH, default 8: entries; power of two, >= 2.
- REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold, 1..DEPTH.
- REQ-005 SHALL have parameter PACKET_MODE, default 0: 0 = beat mode, 1 = store-and-forward on s_tlast.
- REQ-006 SHALL have LW = $clog2(DEPTH+1) as a derived width.
- REQ-007 SHALL have: clk  input  1  single clock; all state updates on posedge.
- REQ-008 SHALL have: reset  input  1  asynchronous, active-low reset.
- REQ-009 SHALL have: s_tdata  input  N*DATA_WIDTH  upstream beat.
- REQ-010 SHALL have: s_tvalid  input  1  upstream beat valid.
- REQ-011 SHALL have: s_tlast  input  1  upstream beat ends a packet.
- REQ-012 SHALL have: s_tready  output  1  FIFO can accept a beat.
- REQ-013 SHALL have: m_tdata  output  N*DATA_WIDTH  head beat.
- REQ-014 SHALL have: m_tlast  output  1  tlast stored with the head beat.
- REQ-015 SHALL have: m_tvalid  output  1  head beat offered downstream.
- REQ-016 SHALL have: m_tready  input  1  downstream accepts.
- REQ-017 SHALL have: level  output  LW  stored-beat count.
- REQ-018 SHALL have: almost_full  output  1  level >= AF_LEVEL.
- REQ-019 SHALL have: pkt_count  output  LW  stored beats with tlast=1.

Function
- REQ-020 SHALL store each entry as {tlast, tdata} in a DEPTH-entry circular register array with rd_ptr/wr_ptr wrapping from DEPTH-1 to 0.
- REQ-021 SHALL define push = s_tvalid & s_tready and pop = m_tvalid & m_tready, both sampled on posedge clk.
- REQ-022 SHALL drive s_tready = (level != DEPTH), combinationally from state only, never from s_tvalid.
- REQ-023 SHALL refuse a beat at full even when pop occurs in the same cycle (s_tready stays 0 at full).
- REQ-024 SHALL drive m_tdata/m_tlast combinationally from the entry at rd_ptr.
- REQ-025 SHALL, at level 0, give 1-cycle latency: a beat pushed at edge k appears on m_tvalid/m_tdata after edge k.
- REQ-026 SHALL, in beat mode, drive m_tvalid = (level != 0).
- REQ-027 SHALL, in packet mode, drive m_tvalid = (level != 0) & ((pkt_count != 0) | (level == DEPTH)), with the full override preventing deadlock on an oversize packet.
- REQ-028 SHALL hold m_tdata/m_tlast stable while m_tvalid=1 and m_tready=0.
- REQ-029 SHALL, on simultaneous push and pop at 0 < level < DEPTH, leave level unchanged and advance both pointers.
- REQ-030 SHALL update level +1 on push only, -1 on pop only, and hold it otherwise, never exceeding DEPTH or going below 0.
- REQ-031 SHALL update pkt_count +1 on push with s_tlast=1, -1 on pop with m_tlast=1, and hold it when both occur in the same cycle.
- REQ-032 SHALL compute almost_full combinationally from level.
- REQ-033 SHALL sustain one beat per cycle with continuous s_tvalid and m_tready in beat mode.
- REQ-034 SHALL ignore s_tdata/s_tlast when s_tvalid=0.

Reset
- REQ-035 SHALL, while reset=0 and regardless of clk, clear pointers, level and pkt_count, giving m_tvalid=0, s_tready=1, almost_full=0 (AF_LEVEL>=1), level=0 and pkt_count=0.
- REQ-036 SHALL discard all stored beats, including mid-packet, on reset assertion.
- REQ-037 SHALL NOT require data array contents to be cleared; m_tdata is don't-care while m_tvalid=0.
- REQ-038 SHALL allow the first push on the first posedge after reset deassertion.

Verification
- REQ-039 SHALL cover: DEPTH=8, beat mode, push 0x01..0x08, m_tready=0 -> s_tready=0 after the 8th push, level=8, almost_full=1 from level 6; then m_tready=1 -> 0x01..0x08 out in order.
- REQ-040 SHALL cover: continuous s_tvalid/m_tready=1 for 100 beats -> 100 beats out, level stays 1, no bubbles.
- REQ-041 SHALL cover: PACKET_MODE=1, push 3 beats with tlast on the 3rd -> m_tvalid=0 until after the 3rd push edge, then 3 beats out with m_tlast=1 on the last and pkt_count 1 -> 0.
- REQ-042 SHALL cover: PACKET_MODE=1, DEPTH=8, 10-beat packet -> m_tvalid=1 at level=8 and all 10 beats delivered in order.
- REQ-043 SHALL cover: at level=8, s_tvalid=1 with m_tready=1 -> the offered beat is not accepted that cycle; level=7 after the edge, accepted next cycle.
- REQ-044 SHALL cover: reset=0 asserted mid-packet between clock edges -> m_tvalid=0 and level=0 immediately; after release, a new beat 0xAA is delivered correctly.

Source files
------------

// File: rtl/axi_stream_fifo.sv
// AXI-Stream style FIFO: DEPTH-entry circular buffer of {tlast, tdata} beats
// with occupancy/packet counters and an optional store-and-forward mode that
// only offers data downstream once a complete packet (or a full buffer) is held.
module axi_stream_fifo #(
  parameter int unsigned N           = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AF_LEVEL    = DEPTH - 2,
  parameter bit          PACKET_MODE = 1'b0,
  parameter int unsigned LW          = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N*DATA_WIDTH-1:0]   s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [N*DATA_WIDTH-1:0]   m_tdata,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [LW-1:0]             level,
  output logic                      almost_full,
  output logic [LW-1:0]             pkt_count
);

  localparam int unsigned DW = N * DATA_WIDTH;
  localparam int unsigned EW = DW + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage and bookkeeping state.
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pkt_q, pkt_d;

  logic          full_c;
  logic          empty_c;
  logic          push_c;
  logic          pop_c;
  logic          pkt_in_c;
  logic          pkt_out_c;
  logic [EW-1:0] head_c;

  // Status decode and handshake qualification; s_tready depends on state only.
  always_comb begin
    full_c    = (level_q == LW'(DEPTH));
    empty_c   = (level_q == '0);
    head_c    = mem_q[rd_ptr_q];
    s_tready  = ~full_c;
    if (PACKET_MODE) begin
      // Full override lets an oversize packet drain instead of deadlocking.
      m_tvalid = ~empty_c & ((pkt_q != '0) | full_c);
    end else begin
      m_tvalid = ~empty_c;
    end
    m_tdata     = head_c[DW-1:0];
    m_tlast     = head_c[EW-1];
    push_c      = s_tvalid & s_tready;
    pop_c       = m_tvalid & m_tready;
    pkt_in_c    = push_c & s_tlast;
    pkt_out_c   = pop_c & m_tlast;
    almost_full = (level_q >= LW'(AF_LEVEL));
    level       = level_q;
    pkt_count   = pkt_q;
  end

  // Next-state for pointers and counters.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    unique case ({pkt_in_c, pkt_out_c})
      2'b10:   pkt_d = pkt_q + LW'(1);
      2'b01:   pkt_d = pkt_q - LW'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  // Pointer and counter registers; reset empties the buffer logically.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
    end
  end

  // Beat storage; contents are never cleared, validity comes from level.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
    end
  end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Scoreboard bench for axi_stream_fifo: one beat-mode and one packet-mode
// instance, each checked every cycle against a queue-based reference model.
module tb_axi_stream_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = DEPTH - 2;

  logic        clk;
  logic        reset;
  logic [31:0] s_tdata  [2];
  logic        s_tvalid [2];
  logic        s_tlast  [2];
  logic        s_tready [2];
  logic [31:0] m_tdata  [2];
  logic        m_tlast  [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic [3:0]  level    [2];
  logic        af       [2];
  logic [3:0]  pkt_count[2];

  int total = 0;
  int bad   = 0;
  int pops  [2];
  bit fullv [2];

  axi_stream_fifo #(.N(4), .DATA_WIDTH(8), .DEPTH(DEPTH), .PACKET_MODE(1'b0)) u_beat (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tlast(s_tlast[0]), .s_tready(s_tready[0]),
    .m_tdata(m_tdata[0]), .m_tlast(m_tlast[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]),
    .level(level[0]), .almost_full(af[0]), .pkt_count(pkt_count[0])
  );

  axi_stream_fifo #(.N(4), .DATA_WIDTH(8), .DEPTH(DEPTH), .PACKET_MODE(1'b1)) u_pkt (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tlast(s_tlast[1]), .s_tready(s_tready[1]),
    .m_tdata(m_tdata[1]), .m_tlast(m_tlast[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]),
    .level(level[1]), .almost_full(af[1]), .pkt_count(pkt_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int g, input string nm, input longint unsigned act,
                     input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
    end
  endtask

  // Reference model + output monitor per instance.
  for (genvar g = 0; g < 2; g++) begin : g_sb
    localparam bit PM = (g == 1);
    logic [32:0] exp_q[$];
    bit          will_push = 1'b0;
    int          lvl;
    int          pk;
    bit          ev;

    always @(negedge reset) begin
      exp_q.delete();
      will_push = 1'b0;
    end

    always @(negedge clk) begin
      if (reset) begin
        lvl = exp_q.size();
        pk  = 0;
        foreach (exp_q[i]) if (exp_q[i][32]) pk++;
        ev = (lvl != 0) && (!PM || pk != 0 || lvl == DEPTH);
        chk(g, "level", level[g], lvl);
        chk(g, "pkt_count", pkt_count[g], pk);
        chk(g, "s_tready", s_tready[g], lvl != DEPTH);
        chk(g, "m_tvalid", m_tvalid[g], ev);
        chk(g, "almost_full", af[g], lvl >= AF);
        if (level[g] == 4'(DEPTH) && m_tvalid[g]) fullv[g] = 1'b1;
        if (ev && m_tready[g]) begin
          chk(g, "beat", {m_tlast[g], m_tdata[g]}, exp_q[0]);
          void'(exp_q.pop_front());
          pops[g]++;
        end
        will_push = s_tvalid[g] && (lvl != DEPTH);
      end
    end

    always @(posedge clk) begin
      if (reset && will_push) exp_q.push_back({s_tlast[g], s_tdata[g]});
      will_push = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the handshake completes.
  task automatic send(input int g, input logic [31:0] d, input bit l);
    bit acc = 1'b0;
    s_tvalid[g] = 1'b1;
    s_tdata[g]  = d;
    s_tlast[g]  = l;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = s_tready[g];
      @(posedge clk);
      #1;
    end
    if (!acc) chk(g, "send_timeout", 0, 1);
    s_tvalid[g] = 1'b0;
  endtask

  int p;

  initial begin
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      s_tdata[g] = '0; s_tvalid[g] = 1'b0; s_tlast[g] = 1'b0; m_tready[g] = 1'b0;
      pops[g] = 0; fullv[g] = 1'b0;
    end
    #3;
    for (int g = 0; g < 2; g++) begin
      chk(g, "rst_level", level[g], 0);
      chk(g, "rst_pkt", pkt_count[g], 0);
      chk(g, "rst_tready", s_tready[g], 1);
      chk(g, "rst_tvalid", m_tvalid[g], 0);
      chk(g, "rst_af", af[g], 0);
    end
    #19 reset = 1'b1;
    cyc();

    // Fill to full with the sink stalled, then drain in order.
    for (int i = 1; i <= 8; i++) send(0, 32'(i), 1'b0);
    chk(0, "full_tready", s_tready[0], 0);
    chk(0, "full_level", level[0], 8);
    chk(0, "full_af", af[0], 1);
    m_tready[0] = 1'b1;
    repeat (9) cyc();
    chk(0, "drained_level", level[0], 0);

    // At full, a concurrent pop does not open the input that cycle.
    m_tready[0] = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 32'h10 + 32'(i), 1'b0);
    m_tready[0] = 1'b1;
    s_tvalid[0] = 1'b1; s_tdata[0] = 32'h99; s_tlast[0] = 1'b0;
    cyc();
    chk(0, "refused_level", level[0], 7);
    cyc();
    chk(0, "accepted_level", level[0], 7);
    s_tvalid[0] = 1'b0;
    repeat (8) cyc();
    chk(0, "drain2_level", level[0], 0);

    // Streaming without bubbles.
    p = pops[0];
    s_tvalid[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tdata[0] = 32'h1000 + 32'(i);
      cyc();
    end
    chk(0, "stream_level", level[0], 1);
    s_tvalid[0] = 1'b0;
    cyc();
    chk(0, "stream_beats", pops[0] - p, 100);

    // Packet mode: hold until tlast arrives.
    p = pops[1];
    m_tready[1] = 1'b1;
    send(1, 32'hA1, 1'b0);
    send(1, 32'hA2, 1'b0);
    send(1, 32'hA3, 1'b1);
    chk(1, "pkt_valid", m_tvalid[1], 1);
    chk(1, "pkt_cnt1", pkt_count[1], 1);
    repeat (4) cyc();
    chk(1, "pkt_cnt0", pkt_count[1], 0);
    chk(1, "pkt_beats", pops[1] - p, 3);

    // Oversize packet drains via the full override.
    p = pops[1];
    fullv[1] = 1'b0;
    for (int i = 0; i < 10; i++) send(1, 32'h2000 + 32'(i), i == 9);
    repeat (12) cyc();
    chk(1, "big_fullvalid", fullv[1], 1);
    chk(1, "big_beats", pops[1] - p, 10);
    chk(1, "big_level", level[1], 0);

    // Asynchronous reset mid-packet.
    m_tready[0] = 1'b0; m_tready[1] = 1'b0;
    send(0, 32'h55, 1'b0);
    send(0, 32'h56, 1'b1);
    send(1, 32'h61, 1'b0);
    send(1, 32'h62, 1'b0);
    chk(0, "pre_rst_valid", m_tvalid[0], 1);
    #2 reset = 1'b0;
    #1;
    chk(0, "async_valid", m_tvalid[0], 0);
    chk(0, "async_level", level[0], 0);
    chk(0, "async_pkt", pkt_count[0], 0);
    chk(1, "async_valid", m_tvalid[1], 0);
    chk(1, "async_level", level[1], 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    cyc();
    m_tready[1] = 1'b1;
    p = pops[1];
    send(1, 32'hAA, 1'b1);
    repeat (3) cyc();
    chk(1, "post_rst_beats", pops[1] - p, 1);
    chk(1, "post_rst_level", level[1], 0);

    // Randomised traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int g = 0; g < 2; g++) begin
        s_tvalid[g] = ($urandom % 4) != 0;
        s_tdata[g]  = $urandom;
        s_tlast[g]  = ($urandom % 4) == 0;
        m_tready[g] = ($urandom % 3) != 0;
      end
      cyc();
    end
    s_tvalid[0] = 1'b0; s_tvalid[1] = 1'b0;
    m_tready[0] = 1'b1; m_tready[1] = 1'b1;
    send(1, 32'hEE, 1'b1);
    repeat (20) cyc();
    chk(0, "final_level", level[0], 0);
    chk(1, "final_level", level[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
